// File: rtl/multi_timer_pkg.sv
// Shared definitions for the multi-channel timer: register selectors, CTRL
// bit positions, channel block stride and the address decode helper.
package multi_timer_pkg;

  localparam int unsigned DATA_W        = 32;
  localparam int unsigned MT_CH_STRIDE  = 32'h10;
  localparam int unsigned CTRL_EN       = 0;
  localparam int unsigned CTRL_PERIODIC = 1;

  typedef enum logic [2:0] {
    MT_MTIME,
    MT_PEND,
    MT_EN,
    CH_CTRL,
    CH_LOAD,
    CH_COUNT,
    MT_NONE
  } mt_reg_e;

  // Map a word address (byte address bits [7:2]) to a register selector.
  // Block 0 is the global block; block c+1 belongs to channel c.
  function automatic mt_reg_e mt_decode(input logic [5:0] word_addr,
                                        input int unsigned nr_ch);
    logic [3:0] blk;
    logic [1:0] word;
    blk  = 4'(32'({word_addr, 2'b00}) / MT_CH_STRIDE);
    word = word_addr[1:0];
    if (blk == 4'd0) begin
      case (word)
        2'd0:    return MT_MTIME;
        2'd1:    return MT_PEND;
        2'd2:    return MT_EN;
        default: return MT_NONE;
      endcase
    end else if (32'(blk) <= nr_ch) begin
      case (word)
        2'd0:    return CH_CTRL;
        2'd1:    return CH_LOAD;
        2'd2:    return CH_COUNT;
        default: return MT_NONE;
      endcase
    end
    return MT_NONE;
  endfunction

endpackage

// File: rtl/multi_timer_channel.sv
// One down-counting timer channel (periodic or one-shot).
// Ports: clk, rst (sync, active-low), tick_i (1 us strobe), ctrl_we_i /
// load_we_i (word writes to CTRL / LOAD), wdata_i (bus write data),
// ctrl_o {PERIODIC, EN}, load_o, count_o (all registered), fire_c_o
// (combinational strobe in the tick cycle the count expires).
module timer_channel
  import multi_timer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              tick_i,
  input  logic              ctrl_we_i,
  input  logic              load_we_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [1:0]        ctrl_o,
  output logic [DATA_W-1:0] load_o,
  output logic [DATA_W-1:0] count_o,
  output logic              fire_c_o
);

  logic              en_q, en_d;
  logic              per_q, per_d;
  logic [DATA_W-1:0] load_q, load_d;
  logic [DATA_W-1:0] count_q, count_d;
  logic              fire_c;

  // Next-state: tick processing first, bus writes override afterwards.
  always_comb begin
    en_d    = en_q;
    per_d   = per_q;
    load_d  = load_q;
    count_d = count_q;
    fire_c  = 1'b0;

    // COUNT==0 holds forever, so LOAD=0 gives a dormant channel.
    if (tick_i && en_q && (count_q != '0)) begin
      if (count_q == DATA_W'(1)) begin
        fire_c = 1'b1;
        if (per_q) begin
          count_d = load_q;
        end else begin
          count_d = '0;
          en_d    = 1'b0;
        end
      end else begin
        count_d = count_q - DATA_W'(1);
      end
    end

    if (load_we_i) begin
      load_d = wdata_i;
    end

    // A CTRL write beats a same-cycle one-shot expiry; only a rising EN reloads.
    if (ctrl_we_i) begin
      en_d  = wdata_i[CTRL_EN];
      per_d = wdata_i[CTRL_PERIODIC];
      if (wdata_i[CTRL_EN] && !en_q) begin
        count_d = load_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      en_q    <= 1'b0;
      per_q   <= 1'b0;
      load_q  <= '0;
      count_q <= '0;
    end else begin
      en_q    <= en_d;
      per_q   <= per_d;
      load_q  <= load_d;
      count_q <= count_d;
    end
  end

  assign ctrl_o[CTRL_EN]       = en_q;
  assign ctrl_o[CTRL_PERIODIC] = per_q;
  assign load_o                = load_q;
  assign count_o               = count_q;
  assign fire_c_o              = fire_c;

endmodule

// File: rtl/multi_timer.sv
// Multi-channel timer peripheral on the UIBI bus: 1 us prescaler, free-running
// MTIME stamp, NR_CH down-counting channels, pend/enable interrupt merge.
// Ports: clk, rst (sync, active-low), intr (registered level interrupt),
// bus_req/bus_wen/bus_mode/bus_addr/bus_dat_i (UIBI request), bus_dat_o
// (registered read data), bus_ready (tied high).
module multi_timer
  import multi_timer_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ  = 100000000,
  parameter int unsigned NR_CLOCK_US = CLOCK_FREQ / 1000000,
  parameter int unsigned NR_CH       = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        intr,
  input  logic        bus_req,
  input  logic        bus_wen,
  input  logic [1:0]  bus_mode,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_dat_i,
  output logic [31:0] bus_dat_o,
  output logic        bus_ready
);

  localparam int unsigned PRESC_W   = 16;
  localparam logic [1:0]  MODE_WORD = 2'b10;

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [DATA_W-1:0]  mtime_q, mtime_d;
  logic [NR_CH-1:0]   pend_q, pend_d;
  logic [NR_CH-1:0]   ien_q, ien_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               intr_q, intr_d;

  logic               tick_c;
  logic               wr_c;
  mt_reg_e            reg_sel_c;
  logic [3:0]         blk_c;
  logic [3:0]         ch_idx_c;
  logic [NR_CH-1:0]   ctrl_we_c, load_we_c, fire_c;
  logic               unused_addr_c;

  logic [1:0]         ch_ctrl  [NR_CH];
  logic [DATA_W-1:0]  ch_load  [NR_CH];
  logic [DATA_W-1:0]  ch_count [NR_CH];

  // Tick is gated by rst so the release cycle never counts.
  assign tick_c    = rst && (presc_q == PRESC_W'(NR_CLOCK_US - 1));
  assign wr_c      = bus_req && bus_wen && (bus_mode == MODE_WORD);
  assign reg_sel_c = mt_decode(bus_addr[7:2], NR_CH);
  assign blk_c     = bus_addr[7:4];
  assign ch_idx_c  = blk_c - 4'd1;

  assign unused_addr_c = ^{bus_addr[31:8], bus_addr[1:0]};

  // Channel instances and their write strobes.
  for (genvar g = 0; g < NR_CH; g++) begin : g_ch
    assign ctrl_we_c[g] = wr_c && (reg_sel_c == CH_CTRL) && (blk_c == 4'(g + 1));
    assign load_we_c[g] = wr_c && (reg_sel_c == CH_LOAD) && (blk_c == 4'(g + 1));

    timer_channel u_ch (
      .clk       (clk),
      .rst       (rst),
      .tick_i    (tick_c),
      .ctrl_we_i (ctrl_we_c[g]),
      .load_we_i (load_we_c[g]),
      .wdata_i   (bus_dat_i),
      .ctrl_o    (ch_ctrl[g]),
      .load_o    (ch_load[g]),
      .count_o   (ch_count[g]),
      .fire_c_o  (fire_c[g])
    );
  end

  // Time base, interrupt state and read mux next-state.
  always_comb begin
    presc_d = tick_c ? '0 : presc_q + PRESC_W'(1);
    mtime_d = tick_c ? mtime_q + DATA_W'(1) : mtime_q;
    ien_d   = ien_q;
    pend_d  = pend_q;
    rdata_d = '0;

    if (wr_c && (reg_sel_c == MT_EN)) begin
      ien_d = bus_dat_i[NR_CH-1:0];
    end
    if (wr_c && (reg_sel_c == MT_PEND)) begin
      pend_d = pend_q & ~bus_dat_i[NR_CH-1:0];
    end
    // Hardware set applied last so it beats a same-cycle W1C.
    pend_d = pend_d | fire_c;

    intr_d = |(pend_q & ien_q);

    if (bus_req) begin
      case (reg_sel_c)
        MT_MTIME: rdata_d = mtime_q;
        MT_PEND:  rdata_d = DATA_W'(pend_q);
        MT_EN:    rdata_d = DATA_W'(ien_q);
        CH_CTRL, CH_LOAD, CH_COUNT: begin
          for (int unsigned c = 0; c < NR_CH; c++) begin
            if (ch_idx_c == 4'(c)) begin
              if (reg_sel_c == CH_CTRL) begin
                rdata_d = DATA_W'(ch_ctrl[c]);
              end else if (reg_sel_c == CH_LOAD) begin
                rdata_d = ch_load[c];
              end else begin
                rdata_d = ch_count[c];
              end
            end
          end
        end
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      presc_q <= '0;
      mtime_q <= '0;
      pend_q  <= '0;
      ien_q   <= '0;
      rdata_q <= '0;
      intr_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      mtime_q <= mtime_d;
      pend_q  <= pend_d;
      ien_q   <= ien_d;
      rdata_q <= rdata_d;
      intr_q  <= intr_d;
    end
  end

  assign intr      = intr_q;
  assign bus_dat_o = rdata_q;
  assign bus_ready = 1'b1;

endmodule
